switch_debounce: RTL
====================

# switch_debounce

Input-conditioning stage placed directly upstream of `soc_mini_top`, between the board DIP switches and its `switch[7:0]` port. It synchronises each raw switch bit into `clk`, debounces it with a per-bit stability counter, and drives a clean `sw_stable` bus into the SoC. It also raises a sticky change-event with a valid/ready handshake so software-visible logic can learn which bits toggled without polling.

## Interface
Parameters:
- `SW_W`, 8, number of switch bits.
- `DB_CYCLES`, 1_000_000, consecutive synchronised cycles a new level must hold before it is accepted (20 ms at 50 MHz). Legal range is 2 and above.
- `RST_VAL`, 8'h00, reset value of synchroniser flops and `sw_stable`.

Ports:
- `clk`, in, 1, single system clock.
- `resetn`, in, 1, asynchronous active-low reset.
- `sw_raw`, in, SW_W, asynchronous board switch levels.
- `sw_stable`, out, SW_W, debounced levels, feeding `soc_mini_top.switch`.
- `evt_valid`, out, 1, one or more bits changed since the last accepted event.
- `evt_mask`, out, SW_W, bits that toggled since the last accept (sticky OR).
- `evt_ready`, in, 1, consumer accepts the event.

## Operation
- Reset is asynchronous. On reset: both sync stages = RST_VAL, `sw_stable` = RST_VAL, all counters = 0, `evt_valid` = 0, `evt_mask` = 0.
- Synchroniser: two flops per bit, `sync1` then `sync2`. No combinational path from `sw_raw`.
- Per-bit counter width is `$clog2(DB_CYCLES)`.
  - If `sync2[i] == sw_stable[i]`: counter clears to 0.
  - Otherwise, if counter == DB_CYCLES-1: `sw_stable[i]` flips, counter clears, and `flip[i]` = 1 for that edge.
  - Otherwise: counter increments.
  - A single mismatching-then-matching glitch restarts the count.
- Event logic (same edge as `sw_stable` update):
  - `accept = evt_valid & evt_ready`.
  - `evt_mask_next = (accept ? 0 : evt_mask) | flip`.
  - `evt_valid_next = |evt_mask_next`.
- Simultaneous accept and new flip: the mask holds only the new flips and `evt_valid` stays 1. No change is lost.
- A bit toggling twice before accept still shows 1 in `evt_mask`. The final level is read from `sw_stable`.
- `evt_mask` and `evt_valid` are stable while `evt_valid` = 1 and `evt_ready` = 0, except for OR-ing in new flips.
- `evt_ready` while `evt_valid` = 0 has no effect.
- If `sw_raw` differs from RST_VAL out of reset, a normal debounce occurs and an event is raised. This is intended.

## Timing
- `sw_raw` change sampled at edge 0 appears in `sync2` after edge 1.
- `sw_stable` flips at edge 1+DB_CYCLES if the level holds. Total latency is DB_CYCLES+1 edges after first capture.
- `evt_valid` rises on the same edge `sw_stable` flips. It is registered, with zero extra latency.
- Pulse shorter than DB_CYCLES synchronised cycles: no output change, no event.
- Reset mid-count: counter, stable, and event state all return to reset values immediately (asynchronously).
- All outputs are registered. `evt_ready` to internal-state is the only combinational input path; no input-to-output combinational path.

## Structure
- Shared package `soc_io_pkg`: `SW_W` default and `DB_CYCLES_SIM` = 4, `DB_CYCLES_BOARD` = 1_000_000 constants, used by the SoC top and the benches.
- Sub-module `debounce_bit`: sync pair, counter, stable flop, and `flip` output. It is instantiated SW_W times via generate.
- Event accumulator lives in `switch_debounce`.

## Test plan
All scenarios use DB_CYCLES=4 and RST_VAL=8'h00.
- Reset with `sw_raw`=8'h00, release, hold 20 cycles -> `sw_stable`=00 and `evt_valid`=0 throughout.
- `sw_raw` 00->8'hFA (the SoC bench value `~8'h05`), held -> `sw_stable`=FA exactly 5 edges after the change edge. `evt_valid`=1 and `evt_mask`=FA on that edge.
- Bit 0 bounces 1,0,1,0 on alternate cycles, then settles at 1 -> no change during the bounce. `sw_stable[0]`=1 4 synced cycles after settling.
- `evt_ready` held 0 while bit 1 then bit 6 flip -> `evt_mask`=8'h42, `evt_valid` stays 1. Pulse `evt_ready` -> mask 00, valid 0 the next cycle.
- `evt_ready`=1 on the exact edge bit 3 flips while mask=8'h01 is pending -> after the edge, mask=8'h08 and valid=1.
- Assert `resetn`=0 two cycles into a debounce of 8'hFF -> `sw_stable`=00 and `evt_valid`=0 immediately. After release, the full DB_CYCLES+1 latency applies again.

Source files
------------

// File: rtl/soc_io_pkg.sv
// Shared constants for the SoC I/O conditioning path and its benches.
package soc_io_pkg;

    localparam int SW_W_DEF        = 8;
    localparam int DB_CYCLES_SIM   = 4;
    localparam int DB_CYCLES_BOARD = 1_000_000;

endpackage

// File: rtl/debounce_bit.sv
// One switch bit: two-flop synchroniser, stability counter and debounced level.
module debounce_bit
    import soc_io_pkg::*;
#(
    parameter int   DB_CYCLES = DB_CYCLES_BOARD,
    parameter logic RST_VAL   = 1'b0
) (
    input  logic clk,
    input  logic resetn,
    input  logic raw,
    output logic stable,
    output logic flip
);

    localparam int             CW      = $clog2(DB_CYCLES);
    localparam logic [CW-1:0]  CNT_MAX = CW'(DB_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    // flip is the decision taken on the coming edge, consumed by the event logic
    always_comb begin
        flip = (sync2 != stable) && (cnt == CNT_MAX);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync1  <= RST_VAL;
            sync2  <= RST_VAL;
            stable <= RST_VAL;
            cnt    <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            if (sync2 == stable) begin
                cnt <= '0;
            end else if (flip) begin
                cnt    <= '0;
                stable <= ~stable;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/switch_debounce.sv
// Debounces the board switch bus and accumulates toggled bits into a sticky event.
module switch_debounce
    import soc_io_pkg::*;
#(
    parameter int              SW_W      = SW_W_DEF,
    parameter int              DB_CYCLES = DB_CYCLES_BOARD,
    parameter logic [SW_W-1:0] RST_VAL   = '0
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic [SW_W-1:0] sw_raw,
    output logic [SW_W-1:0] sw_stable,
    output logic            evt_valid,
    output logic [SW_W-1:0] evt_mask,
    input  logic            evt_ready
);

    logic [SW_W-1:0] flip;
    logic [SW_W-1:0] evt_mask_next;
    logic            accept;

    for (genvar i = 0; i < SW_W; i++) begin : g_bit
        debounce_bit #(
            .DB_CYCLES (DB_CYCLES),
            .RST_VAL   (RST_VAL[i])
        ) u_bit (
            .clk    (clk),
            .resetn (resetn),
            .raw    (sw_raw[i]),
            .stable (sw_stable[i]),
            .flip   (flip[i])
        );
    end

    // A flip landing on the accept edge starts the next event instead of being dropped
    always_comb begin
        accept        = evt_valid & evt_ready;
        evt_mask_next = (accept ? '0 : evt_mask) | flip;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            evt_mask  <= '0;
            evt_valid <= 1'b0;
        end else begin
            evt_mask  <= evt_mask_next;
            evt_valid <= |evt_mask_next;
        end
    end

endmodule
